// File: rtl/parallel_converter_n_to_1_if.sv
// Bus-side signals of the N-to-1 parallel converter: one wide tagged bus in,
// one tagged block per cycle out, plus shadow-ready and drop indication.
interface parallel_converter_n_to_1_if #(
  parameter int NB_DATA_TAGGED = 67,
  parameter int N_LANES        = 20
) ();
  localparam int NB_DATA_BUS = NB_DATA_TAGGED * N_LANES;

  logic                      i_valid;
  logic [NB_DATA_BUS-1:0]    i_data;
  logic                      o_valid;
  logic [NB_DATA_TAGGED-1:0] o_data;
  logic                      o_ready;
  logic                      o_overflow;

  modport master (
    output i_valid,
    output i_data,
    input  o_valid,
    input  o_data,
    input  o_ready,
    input  o_overflow
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_valid,
    output o_data,
    output o_ready,
    output o_overflow
  );
endinterface

// File: rtl/parallel_converter_n_to_1.sv
// N-to-1 parallel converter: re-serializes an N_LANES-wide bus of tagged
// blocks into one block per enabled clock, oldest block first. An active
// buffer feeds the output while a shadow buffer holds the next bus, so
// back-to-back buses stream without bubbles; a third bus is dropped.
module parallel_converter_n_to_1 #(
  parameter int NB_DATA_TAGGED = 67,
  parameter int N_LANES        = 20,
  parameter int NB_DATA_BUS    = NB_DATA_TAGGED * N_LANES
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  parallel_converter_n_to_1_if.slave  bus
);

  localparam int                  NB_INDEX   = $clog2(N_LANES);
  localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(N_LANES - 1);

  logic [NB_DATA_BUS-1:0]    active_reg;
  logic [NB_DATA_BUS-1:0]    shadow_reg;
  logic                      active_full;
  logic                      shadow_full;
  logic [NB_INDEX-1:0]       index;
  logic [NB_DATA_TAGGED-1:0] lane [N_LANES];
  logic                      handoff;

  // Split the active bus into lanes ordered by arrival: lane 0 is the oldest
  // block, which sits in the most significant slice.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      lane[i] = active_reg[(N_LANES-1-i)*NB_DATA_TAGGED +: NB_DATA_TAGGED];
    end
  end

  assign handoff     = active_full && (index == LAST_INDEX);
  assign bus.o_ready = ~shadow_full;

  // Emission, buffer management and drop detection; the handoff edge emits
  // the last slice and refills the active buffer in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      active_reg     <= '0;
      shadow_reg     <= '0;
      active_full    <= 1'b0;
      shadow_full    <= 1'b0;
      index          <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_data     <= '0;
      bus.o_overflow <= 1'b0;
    end else begin
      bus.o_valid    <= 1'b0;
      bus.o_overflow <= 1'b0;
      if (i_enable) begin
        if (active_full) begin
          bus.o_data  <= lane[index];
          bus.o_valid <= 1'b1;
          index       <= index + 1'b1;
        end
        if (handoff) begin
          index <= '0;
          if (shadow_full) begin
            active_reg <= shadow_reg;
            if (bus.i_valid) begin
              shadow_reg <= bus.i_data;
            end else begin
              shadow_full <= 1'b0;
            end
          end else if (bus.i_valid) begin
            active_reg <= bus.i_data;
          end else begin
            active_full <= 1'b0;
          end
        end else if (bus.i_valid) begin
          if (!active_full) begin
            active_reg  <= bus.i_data;
            active_full <= 1'b1;
            index       <= '0;
          end else if (!shadow_full) begin
            shadow_reg  <= bus.i_data;
            shadow_full <= 1'b1;
          end else begin
            bus.o_overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_parallel_converter_n_to_1.sv
// Testbench for parallel_converter_n_to_1: a 4x8 instance driven by directed
// and random stimulus against a bus-queue reference model, and a default
// 67x20 instance streamed at full rate against an expected block queue.
module tb_parallel_converter_n_to_1;

  localparam int NS      = 4;
  localparam int NBS     = 8;
  localparam int NB_BIG  = 67;
  localparam int N_BIG   = 20;
  localparam int BUS_BIG = NB_BIG * N_BIG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_s;
  logic en_b;

  parallel_converter_n_to_1_if #(.NB_DATA_TAGGED(NBS),    .N_LANES(NS))    sif ();
  parallel_converter_n_to_1_if #(.NB_DATA_TAGGED(NB_BIG), .N_LANES(N_BIG)) bif ();

  parallel_converter_n_to_1 #(.NB_DATA_TAGGED(NBS), .N_LANES(NS)) u_small (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_enable (en_s),
    .bus      (sif.slave)
  );

  parallel_converter_n_to_1 #(.NB_DATA_TAGGED(NB_BIG), .N_LANES(N_BIG)) u_big (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_enable (en_b),
    .bus      (bif.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: at most two whole buses held in arrival order; the
  // oldest one is emitted one block per enabled cycle.
  logic [31:0]    mq[$];
  int             mpos      = 0;
  logic           exp_valid = 1'b0;
  logic [NBS-1:0] exp_data  = '0;
  logic           exp_ovf   = 1'b0;
  logic           exp_ready = 1'b1;
  logic [NBS-1:0] mlog[$];

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mpos      = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_ovf   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      if (en_s) begin
        if (mq.size() > 0) begin
          logic [31:0] cur;
          cur       = mq[0];
          exp_valid = 1'b1;
          exp_data  = cur[31 - NBS*mpos -: NBS];
          mlog.push_back(exp_data);
          mpos++;
          if (mpos == NS) begin
            void'(mq.pop_front());
            mpos = 0;
          end
        end
        if (sif.i_valid) begin
          if (mq.size() < 2) mq.push_back(sif.i_data);
          else exp_ovf = 1'b1;
        end
      end
    end
    exp_ready = (mq.size() < 2);
  end

  // Per-cycle comparison of the small instance against the model.
  bit chk_en      = 1'b0;
  int dut_ovf_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid",    sif.o_valid,    exp_valid);
      check("o_data",     sif.o_data,     exp_data);
      check("o_overflow", sif.o_overflow, exp_ovf);
      check("o_ready",    sif.o_ready,    exp_ready);
      if (sif.o_overflow === 1'b1) dut_ovf_cnt++;
    end
  end

  // Expected block stream of the default-size instance.
  logic [NB_BIG-1:0] bq[$];
  int big_cyc   = 0;
  int big_cnt   = 0;
  int big_first = -1;
  int big_last  = -1;
  int big_ovf   = 0;

  always @(negedge clk) begin
    big_cyc++;
    if (bif.o_overflow === 1'b1) big_ovf++;
    if (bif.o_valid === 1'b1) begin
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL big_extra_block actual=%0h required=none", bif.o_data);
      end else begin
        check("big_block", bif.o_data, bq.pop_front());
      end
      big_cnt++;
      if (big_first < 0) big_first = big_cyc;
      big_last = big_cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    sif.i_valid = v;
    sif.i_data  = d;
  endtask

  // Compare the model's emitted sequence against a hand-written literal.
  task automatic check_log(input string name, input int n, input logic [63:0] expected);
    check({name, "_len"}, mlog.size(), n);
    for (int i = 0; i < n && i < mlog.size(); i++) begin
      check(name, mlog[i], expected[NBS*(n-1-i) +: NBS]);
    end
    mlog.delete();
  endtask

  task automatic send_big();
    logic [BUS_BIG+31:0] tmp;
    logic [BUS_BIG-1:0]  b;
    for (int k = 0; k < (BUS_BIG + 31) / 32; k++) tmp[k*32 +: 32] = $urandom;
    b = tmp[BUS_BIG-1:0];
    for (int j = 0; j < N_BIG; j++) bq.push_back(b[BUS_BIG-1 - NB_BIG*j -: NB_BIG]);
    bif.i_valid = 1'b1;
    bif.i_data  = b;
  endtask

  initial begin
    int ovf0;
    rst         = 1'b1;
    en_s        = 1'b1;
    en_b        = 1'b1;
    sif.i_valid = 1'b0;
    sif.i_data  = '0;
    bif.i_valid = 1'b0;
    bif.i_data  = '0;
    tick(2);
    chk_en = 1'b1;
    check("reset_o_valid", sif.o_valid, 1'b0);
    check("reset_o_data",  sif.o_data,  8'h00);
    check("reset_o_ready", sif.o_ready, 1'b1);
    rst = 1'b0;
    tick(1);

    // Single bus.
    mlog.delete();
    ovf0 = dut_ovf_cnt;
    drive(1'b1, 32'hA1B2C3D4);
    tick(1);
    drive(1'b0, 32'h0);
    tick(7);
    check_log("single", 4, 64'hA1B2C3D4);
    check("single_no_overflow", dut_ovf_cnt - ovf0, 0);

    // Second bus offered on the handoff edge.
    drive(1'b1, 32'hA1B2C3D4);
    tick(1);
    drive(1'b0, 32'h0);
    tick(3);
    drive(1'b1, 32'h11223344);
    tick(1);
    drive(1'b0, 32'h0);
    tick(8);
    check_log("b2b", 8, 64'hA1B2C3D4_11223344);

    // Three buses on consecutive cycles: the third is dropped.
    ovf0 = dut_ovf_cnt;
    drive(1'b1, 32'hA1B2C3D4);
    tick(1);
    drive(1'b1, 32'h11223344);
    tick(1);
    drive(1'b1, 32'h99AABBCC);
    tick(1);
    drive(1'b0, 32'h0);
    tick(10);
    check_log("overflow", 8, 64'hA1B2C3D4_11223344);
    check("overflow_pulses", dut_ovf_cnt - ovf0, 1);

    // Enable stall after B2, with a bus offered during the stall.
    drive(1'b1, 32'hA1B2C3D4);
    tick(1);
    drive(1'b0, 32'h0);
    tick(2);
    en_s = 1'b0;
    tick(1);
    drive(1'b1, 32'h5A5A5A5A);
    tick(1);
    drive(1'b0, 32'h0);
    check("stall_hold_data", sif.o_data, 8'hB2);
    tick(1);
    en_s = 1'b1;
    tick(4);
    check_log("stall", 4, 64'hA1B2C3D4);

    // Reset after C3 with the shadow full.
    drive(1'b1, 32'hA1B2C3D4);
    tick(1);
    drive(1'b1, 32'h11223344);
    tick(1);
    drive(1'b0, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_o_valid", sif.o_valid, 1'b0);
    check("rst_mid_o_data",  sif.o_data,  8'h00);
    check("rst_mid_o_ready", sif.o_ready, 1'b1);
    check_log("rst_pre", 3, 64'hA1B2C3);
    drive(1'b1, 32'h55667788);
    tick(1);
    drive(1'b0, 32'h0);
    tick(6);
    check_log("rst_post", 4, 64'h55667788);

    // Random traffic with stalls and one reset.
    for (int c = 0; c < 400; c++) begin
      en_s = ($urandom_range(0, 9) != 0);
      drive(($urandom_range(0, 3) == 0), $urandom);
      rst = (c == 200);
      tick(1);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0);
    en_s = 1'b1;
    tick(12);
    mlog.delete();

    // Default geometry: three buses at the maximum rate.
    big_cnt   = 0;
    big_first = -1;
    big_last  = -1;
    big_ovf   = 0;
    for (int b = 0; b < 3; b++) begin
      send_big();
      tick(1);
      bif.i_valid = 1'b0;
      tick(N_BIG - 1);
    end
    tick(10);
    check("big_block_count", big_cnt, 60);
    check("big_contiguous",  big_last - big_first, 59);
    check("big_queue_empty", bq.size(), 0);
    check("big_no_overflow", big_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
